// File: rtl/sram_pump_arbiter.sv
// sram_pump_arbiter
//   Owns the external SRAM and shares it between the SPI data-pump write stream and the
//   core memory port. The pump always wins. While a pump session is active the core is
//   held in reset. After the session ends, the core is released a programmable number of
//   cycles later.
//
// Ports
//   clk, reset                     system clock, synchronous active-high reset
//   pump_active_i/a_i/d_i/we_n_i   pump session flag and write strobe (sck domain)
//   core_req_i/we_i/a_i/d_i        core access request, held until core_ack_o
//   core_ack_o, core_q_o           one-cycle completion pulse and read data
//   core_reset_o                   holds the core in reset
//   pump_overrun_o                 sticky: a pump strobe arrived before the previous one was
//                                  serviced
//   sram_*                         SRAM pins (address, data out/in, data OE, WE#, OE#)
//
// Optional feature (macro PUMP_CHECKSUM_EN)
//   Adds pump_sum_o[15:0]: the modulo-2^16 sum of every byte the pump has written.
module sram_pump_arbiter #(
    parameter int unsigned ADDR_W         = 19,
    parameter int unsigned WE_CYCLES      = 2,
    parameter int unsigned RD_CYCLES      = 2,
    parameter int unsigned RELEASE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pump_active_i,
    input  logic [ADDR_W-1:0] pump_a_i,
    input  logic [7:0]        pump_d_i,
    input  logic              pump_we_n_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_a_i,
    input  logic [7:0]        core_d_i,
    output logic              core_ack_o,
    output logic [7:0]        core_q_o,
    output logic              core_reset_o,
    output logic              pump_overrun_o,
    output logic [ADDR_W-1:0] sram_a_o,
    output logic [7:0]        sram_dq_o,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_dq_oe_o,
    output logic              sram_we_n_o,
    output logic              sram_oe_n_o
`ifdef PUMP_CHECKSUM_EN
    ,
    output logic [15:0]       pump_sum_o
`endif
);

    localparam logic [3:0] WeLoad = 4'(WE_CYCLES - 1);
    localparam logic [3:0] RdLoad = 4'(RD_CYCLES - 1);
    // The synced-fall detect cycle and the drop edge each count as one release cycle.
    localparam logic [7:0] RelLoad  = (RELEASE_CYCLES > 1) ? 8'(RELEASE_CYCLES - 2) : 8'd0;
    localparam logic       RelShort = (RELEASE_CYCLES <= 1);

    typedef enum logic [2:0] {StIdle, StWrSetup, StWrStrobe, StWrHold, StRdWait} state_e;

    // ------------------------------------------------------------------ synchronizers
    logic [1:0] act_sync_q, wen_sync_q;
    logic       act_prev_q, wen_prev_q;
    logic       act_rise, act_fall, pump_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            act_sync_q <= 2'b00;
            act_prev_q <= 1'b0;
            wen_sync_q <= 2'b11;
            wen_prev_q <= 1'b1;
        end else begin
            act_sync_q <= {act_sync_q[0], pump_active_i};
            act_prev_q <= act_sync_q[1];
            wen_sync_q <= {wen_sync_q[0], pump_we_n_i};
            wen_prev_q <= wen_sync_q[1];
        end
    end

    assign act_rise = act_sync_q[1] & ~act_prev_q;
    assign act_fall = ~act_sync_q[1] & act_prev_q;
    assign pump_evt = wen_prev_q & ~wen_sync_q[1];

    // ------------------------------------------------------------------ pump capture
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pump_a_q;
    logic [7:0]        pump_d_q;
    logic              pend_q, pend_d, overrun_q;

    always_comb begin
        pend_d = pend_q;
        if (state_q == StIdle) pend_d = 1'b0;  // IDLE always takes a pending byte
        if (pump_evt)          pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pump_a_q  <= '0;
            pump_d_q  <= 8'h00;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (pump_evt) begin
                pump_a_q <= pump_a_i;
                pump_d_q <= pump_d_i;
                if (pend_q) overrun_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ core reset release
    logic       core_reset_q, core_reset_d;
    logic       rel_run_q, rel_run_d;
    logic [7:0] rel_cnt_q, rel_cnt_d;
    logic       rel_done;

    always_comb begin
        core_reset_d = core_reset_q;
        rel_run_d    = rel_run_q;
        rel_cnt_d    = rel_cnt_q;
        rel_done     = 1'b0;
        if (act_rise) begin
            core_reset_d = 1'b1;
            rel_run_d    = 1'b0;
        end else if (act_fall) begin
            rel_run_d = 1'b1;
            rel_cnt_d = RelLoad;
            rel_done  = RelShort;
        end else if (rel_run_q) begin
            if (rel_cnt_q != 8'd0) rel_cnt_d = rel_cnt_q - 8'd1;
            else                   rel_done  = 1'b1;
        end
        // An expired count waits here until the memory is quiet.
        if (rel_done && !pend_q && state_q == StIdle) begin
            core_reset_d = 1'b0;
            rel_run_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset_q <= 1'b1;
            rel_run_q    <= 1'b0;
            rel_cnt_q    <= 8'd0;
        end else begin
            core_reset_q <= core_reset_d;
            rel_run_q    <= rel_run_d;
            rel_cnt_q    <= rel_cnt_d;
        end
    end

    // ------------------------------------------------------------------ access FSM
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_pump_q, owner_pump_d;
    logic [ADDR_W-1:0] sram_a_q, sram_a_d;
    logic [7:0]        sram_dq_q, sram_dq_d, core_q_q, core_q_d;
    logic              dq_oe_q, dq_oe_d, we_n_q, we_n_d, oe_n_q, oe_n_d, ack_q, ack_d;
    logic              core_go;

    // A read acks while already back in IDLE with the request still up; ack_q masks it.
    assign core_go = core_req_i && !core_reset_q && !ack_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pend_q)       state_d = StWrSetup;
                else if (core_go) state_d = core_we_i ? StWrSetup : StRdWait;
            end
            StWrSetup:  state_d = StWrStrobe;
            StWrStrobe: if (cnt_q == 4'd0) state_d = StWrHold;
            StWrHold:   state_d = StIdle;
            StRdWait:   if (cnt_q == 4'd0) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        owner_pump_d = owner_pump_q;
        sram_a_d     = sram_a_q;
        sram_dq_d    = sram_dq_q;
        dq_oe_d      = dq_oe_q;
        we_n_d       = we_n_q;
        oe_n_d       = oe_n_q;
        ack_d        = 1'b0;
        core_q_d     = core_q_q;
        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    owner_pump_d = 1'b1;
                    sram_a_d     = pump_a_q;
                    sram_dq_d    = pump_d_q;
                    dq_oe_d      = 1'b1;
                end else if (core_go) begin
                    owner_pump_d = 1'b0;
                    sram_a_d     = core_a_i;
                    if (core_we_i) begin
                        sram_dq_d = core_d_i;
                        dq_oe_d   = 1'b1;
                    end else begin
                        oe_n_d  = 1'b0;
                        dq_oe_d = 1'b0;
                        cnt_d   = RdLoad;
                    end
                end
            end
            StWrSetup: begin
                we_n_d = 1'b0;
                cnt_d  = WeLoad;
            end
            StWrStrobe: begin
                if (cnt_q == 4'd0) begin
                    we_n_d = 1'b1;
                    ack_d  = !owner_pump_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrHold: dq_oe_d = 1'b0;
            StRdWait: begin
                if (cnt_q == 4'd0) begin
                    core_q_d = sram_dq_i;
                    ack_d    = 1'b1;
                    oe_n_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= 4'd0;
            owner_pump_q <= 1'b0;
            sram_a_q     <= '0;
            sram_dq_q    <= 8'h00;
            dq_oe_q      <= 1'b0;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            ack_q        <= 1'b0;
            core_q_q     <= 8'h00;
        end else begin
            cnt_q        <= cnt_d;
            owner_pump_q <= owner_pump_d;
            sram_a_q     <= sram_a_d;
            sram_dq_q    <= sram_dq_d;
            dq_oe_q      <= dq_oe_d;
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
            ack_q        <= ack_d;
            core_q_q     <= core_q_d;
        end
    end

`ifdef PUMP_CHECKSUM_EN
    logic [15:0] sum_q;
    always_ff @(posedge clk) begin
        if (reset || act_rise)                       sum_q <= 16'h0000;
        else if (state_q == StWrHold && owner_pump_q) sum_q <= sum_q + {8'h00, sram_dq_q};
    end
    assign pump_sum_o = sum_q;
`endif

    assign core_ack_o     = ack_q;
    assign core_q_o       = core_q_q;
    assign core_reset_o   = core_reset_q;
    assign pump_overrun_o = overrun_q;
    assign sram_a_o       = sram_a_q;
    assign sram_dq_o      = sram_dq_q;
    assign sram_dq_oe_o   = dq_oe_q;
    assign sram_we_n_o    = we_n_q;
    assign sram_oe_n_o    = oe_n_q;

endmodule

// File: tb/tb_sram_pump_arbiter.sv
// Directed bench for sram_pump_arbiter with a small SRAM model and a write log.
module tb_sram_pump_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pump_active_i = 1'b0;
    logic [18:0] pump_a_i = '0;
    logic [7:0]  pump_d_i = 8'h00;
    logic        pump_we_n_i = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [18:0] core_a_i = '0;
    logic [7:0]  core_d_i = 8'h00;
    logic        core_ack_o, core_reset_o, pump_overrun_o;
    logic [7:0]  core_q_o, sram_dq_o, sram_dq_i;
    logic [18:0] sram_a_o;
    logic        sram_dq_oe_o, sram_we_n_o, sram_oe_n_o;
`ifdef PUMP_CHECKSUM_EN
    logic [15:0] pump_sum_o;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_pump_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .pump_active_i  (pump_active_i),
        .pump_a_i       (pump_a_i),
        .pump_d_i       (pump_d_i),
        .pump_we_n_i    (pump_we_n_i),
        .core_req_i     (core_req_i),
        .core_we_i      (core_we_i),
        .core_a_i       (core_a_i),
        .core_d_i       (core_d_i),
        .core_ack_o     (core_ack_o),
        .core_q_o       (core_q_o),
        .core_reset_o   (core_reset_o),
        .pump_overrun_o (pump_overrun_o),
        .sram_a_o       (sram_a_o),
        .sram_dq_o      (sram_dq_o),
        .sram_dq_i      (sram_dq_i),
        .sram_dq_oe_o   (sram_dq_oe_o),
        .sram_we_n_o    (sram_we_n_o),
        .sram_oe_n_o    (sram_oe_n_o)
`ifdef PUMP_CHECKSUM_EN
        ,
        .pump_sum_o     (pump_sum_o)
`endif
    );

    // SRAM model (low 13 address bits) and a log of every completed write pulse.
    logic [7:0]  mem [0:8191];
    logic [18:0] log_a [$];
    logic [7:0]  log_d [$];
    int          log_n [$];
    int          low_cnt = 0;
    logic [18:0] cur_a = '0;
    logic [7:0]  cur_d = 8'h00;

    assign sram_dq_i = sram_oe_n_o ? 8'h00 : mem[sram_a_o[12:0]];

    always @(negedge clk) begin
        if (sram_we_n_o === 1'b0) begin
            low_cnt = low_cnt + 1;
            cur_a   = sram_a_o;
            cur_d   = sram_dq_o;
            mem[sram_a_o[12:0]] = sram_dq_o;
        end else if (low_cnt != 0) begin
            log_a.push_back(cur_a);
            log_d.push_back(cur_d);
            log_n.push_back(low_cnt);
            low_cnt = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_last_write(input string tag, input logic [18:0] a, input logic [7:0] d);
        int k;
        k = log_a.size();
        check({tag, "_count_nonzero"}, 32'(k > 0), 1);
        if (k > 0) begin
            check({tag, "_addr"}, 32'(log_a[k-1]), 32'(a));
            check({tag, "_data"}, 32'(log_d[k-1]), 32'(d));
            check({tag, "_we_len"}, 32'(log_n[k-1]), 2);
        end
    endtask

    // Returns the number of clocks until ack (-1 on timeout), then drops the request.
    task automatic wait_ack(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick(1);
            if (core_ack_o === 1'b1) begin
                n = i;
                break;
            end
        end
        core_req_i = 1'b0;
    endtask

    task automatic wait_release(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick(1);
            if (core_reset_o === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    // One sck-paced pump strobe from an idle arbiter; we_n must go low on the 5th clock.
    task automatic pump_byte(input logic [18:0] a, input logic [7:0] d);
        pump_a_i = a;
        pump_d_i = d;
        tick(4);
        pump_we_n_i = 1'b0;
        tick(4);
        check("strobe_lat4_we_n", 32'(sram_we_n_o), 1);
        tick(1);
        check("strobe_lat5_we_n", 32'(sram_we_n_o), 0);
        tick(3);
        pump_we_n_i = 1'b1;
        tick(4);
    endtask

    initial begin
        int n;
        int seen;
        int nwr;

        // Reset state
        tick(3);
        reset = 1'b0;
        tick(2);
        check("rst_core_reset", 32'(core_reset_o), 1);
        check("rst_we_n", 32'(sram_we_n_o), 1);
        check("rst_oe_n", 32'(sram_oe_n_o), 1);
        check("rst_dq_oe", 32'(sram_dq_oe_o), 0);
        check("rst_ack", 32'(core_ack_o), 0);
        check("rst_overrun", 32'(pump_overrun_o), 0);
        check("rst_sram_a", 32'(sram_a_o), 0);
        check("rst_core_q", 32'(core_q_o), 0);

        // Pump session: two bytes, strobes 128 clk (16 sck) apart
        pump_active_i = 1'b1;
        tick(6);
        pump_byte(19'h00000, 8'hA5);
        tick(112);
        pump_byte(19'h00001, 8'h3C);
        tick(8);
        check("pump_write_count", 32'(log_a.size()), 2);
        if (log_a.size() == 2) begin
            check("pump0_addr", 32'(log_a[0]), 'h0);
            check("pump0_data", 32'(log_d[0]), 'hA5);
            check("pump0_we_len", 32'(log_n[0]), 2);
        end
        check_last_write("pump1", 19'h00001, 8'h3C);
        check("pump_overrun", 32'(pump_overrun_o), 0);
        check("pump_core_reset", 32'(core_reset_o), 1);
`ifdef PUMP_CHECKSUM_EN
        check("pump_sum", 32'(pump_sum_o), 'h00E1);
`endif

        // Re-raise during countdown: core stays in reset
        pump_active_i = 1'b0;
        tick(8);
        pump_active_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (core_reset_o !== 1'b1) seen++;
        end
        check("reraise_no_release", 32'(seen), 0);

        // Release latency: RELEASE_CYCLES + 2
        pump_active_i = 1'b0;
        wait_release(100, n);
        check("release_latency", 32'(n), 18);

        // Core write then reads through the SRAM model
        tick(2);
        core_req_i = 1'b1; core_we_i = 1'b1; core_a_i = 19'h01234; core_d_i = 8'h55;
        wait_ack(12, n);
        check("core_wr_ack_latency", 32'(n), 4);
        tick(3);
        check_last_write("core_wr", 19'h01234, 8'h55);
        core_req_i = 1'b1; core_we_i = 1'b0; core_a_i = 19'h01234;
        wait_ack(12, n);
        check("core_rd_ack_latency", 32'(n), 3);
        check("core_rd_data", 32'(core_q_o), 'h55);
        check("core_rd_oe_n_released", 32'(sram_oe_n_o), 1);
        tick(1);
        check("core_ack_one_cycle", 32'(core_ack_o), 0);
        tick(1);
        core_req_i = 1'b1; core_we_i = 1'b0; core_a_i = 19'h00001;
        wait_ack(12, n);
        check("core_rd2_ack_latency", 32'(n), 3);
        check("core_rd2_data", 32'(core_q_o), 'h3C);
        tick(2);

        // Core read in flight when a pump session and strobe start
        nwr = log_a.size();
        pump_a_i = 19'h00007; pump_d_i = 8'h99;
        pump_active_i = 1'b1;
        pump_we_n_i = 1'b0;
        core_req_i = 1'b1; core_we_i = 1'b0; core_a_i = 19'h00001;
        wait_ack(12, n);
        check("inflight_rd_ack_latency", 32'(n), 3);
        check("inflight_rd_data", 32'(core_q_o), 'h3C);
        tick(2);
        check("inflight_pump_follows", 32'(sram_we_n_o), 0);
        pump_we_n_i = 1'b1;
        tick(8);
        check("inflight_write_count", 32'(log_a.size() - nwr), 1);
        check_last_write("inflight_pump", 19'h00007, 8'h99);
        check("inflight_overrun", 32'(pump_overrun_o), 0);
`ifdef PUMP_CHECKSUM_EN
        check("inflight_sum", 32'(pump_sum_o), 'h0099);
`endif

        // No ack while the core is held in reset
        core_req_i = 1'b1; core_we_i = 1'b1; core_a_i = 19'h00030; core_d_i = 8'h77;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (core_ack_o !== 1'b0) seen++;
        end
        core_req_i = 1'b0;
        check("no_ack_in_reset", 32'(seen), 0);

        pump_active_i = 1'b0;
        wait_release(100, n);
        check("release_latency2", 32'(n), 18);
        tick(2);

        // Two pump strobes 2 clk apart during a core write
        nwr = log_a.size();
        core_req_i = 1'b1; core_we_i = 1'b1; core_a_i = 19'h00020; core_d_i = 8'h11;
        pump_a_i = 19'h00040; pump_d_i = 8'hAA;
        pump_we_n_i = 1'b0;
        tick(1);
        pump_we_n_i = 1'b1;
        tick(1);
        pump_we_n_i = 1'b0;
        tick(1);
        pump_a_i = 19'h00041; pump_d_i = 8'h42;
        tick(1);
        pump_we_n_i = 1'b1;
        check("ovr_core_wr_ack", 32'(core_ack_o), 1);
        core_req_i = 1'b0;
        tick(10);
        check("ovr_overrun_set", 32'(pump_overrun_o), 1);
        check("ovr_write_count", 32'(log_a.size() - nwr), 2);
        if (log_a.size() - nwr == 2) begin
            check("ovr_core_addr", 32'(log_a[nwr]), 'h20);
            check("ovr_core_data", 32'(log_d[nwr]), 'h11);
        end
        check_last_write("ovr_pump", 19'h00041, 8'h42);
        tick(20);
        check("ovr_overrun_sticky", 32'(pump_overrun_o), 1);

        // Reset clears the sticky flag and re-holds the core
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rst2_overrun", 32'(pump_overrun_o), 0);
        check("rst2_core_reset", 32'(core_reset_o), 1);

        // Reset in the middle of a pump write returns we_n high on the next clock
        pump_a_i = 19'h00050; pump_d_i = 8'h66;
        pump_we_n_i = 1'b0;
        tick(6);
        check("midwr_we_low", 32'(sram_we_n_o), 0);
        reset = 1'b1;
        pump_we_n_i = 1'b1;
        tick(1);
        check("midwr_we_released", 32'(sram_we_n_o), 1);
        reset = 1'b0;
        tick(4);
        check("midwr_idle_we_n", 32'(sram_we_n_o), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
